placement_registry: RTL and testbench
=====================================

Name: placement_registry

Overview:
- Responder side of the setup placement/collision interface.
- Stores nest and sugar-patch coordinates written during setup, and answers the setup sequencer's combinational collision query for each candidate location.
- Publishes the nest coordinate arrays consumed by ant setup and the game loop.
- In run mode, serves registered location lookups and per-patch sugar depletion.

Parameters:
- NEST_num, 2, number of nests (from params package)
- SUGARPATCH_num, 4, number of sugar patches (from params package)
- X_bits, 8, x coordinate width
- Y_bits, 7, y coordinate width
- MIN_SEP, 4, Chebyshev half-width of the exclusion square around placed objects
- SUGAR_bits, 8, per-patch sugar counter width
- SUGAR_INIT, 255, sugar loaded into a patch on write

Ports:
- setup_clk  in  1  clock
- RESET_SIM  in  1  reset: asynchronous, active-high
- nest_we  in  1  accepted nest placement strobe (asserted only in SETUP_NESTS)
- nest_id  in  NEST_num_bits  nest entry index
- nest_setup_x  in  X_bits  nest x
- nest_setup_y  in  Y_bits  nest y
- patch_we  in  1  accepted patch placement strobe (asserted only in SETUP_FOOD)
- patch_id  in  SUGARPATCH_num_bits  patch entry index
- patch_setup_x  in  X_bits  patch x
- patch_setup_y  in  Y_bits  patch y
- collide_x  in  X_bits  candidate x
- collide_y  in  Y_bits  candidate y
- collision  out  1  candidate inside an exclusion square (combinational)
- nests_X  out  NEST_num x X_bits  stored nest x per entry
- nests_Y  out  NEST_num x Y_bits  stored nest y per entry
- nests_placed  out  1  all nest valid bits set
- patches_placed  out  1  all patch valid bits set
- query_x  in  X_bits  run-mode lookup x
- query_y  in  Y_bits  run-mode lookup y
- q_nest_hit  out  1  query lands exactly on a valid nest
- q_nest_id  out  NEST_num_bits  matching nest index
- q_patch_hit  out  1  query lands inside a live patch square
- q_patch_id  out  SUGARPATCH_num_bits  matching patch index
- take_req  in  1  ant removes one sugar unit
- take_id  in  SUGARPATCH_num_bits  patch to decrement
- take_ack  out  1  pulse: unit granted
- patch_sugar  out  SUGARPATCH_num x SUGAR_bits  remaining sugar per patch

Behaviour:
- Reset (async): all coordinates 0, valid bits 0, sugar 0, all q_* and take_ack 0. collision falls to 0 because no entry is valid.
- Nest write: when nest_we=1, on the clock edge store (x, y) at nest_id and set its valid bit.
- Patch write: when patch_we=1, on the clock edge store (x, y) at patch_id, set valid, and load sugar = SUGAR_INIT.
- Rewrite of an index: overwrites the stored values and stays valid.
- Out-of-range index (>= NUM): ignored.
- collision is purely combinational over the current registered state. It is 1 iff any valid nest or valid patch e satisfies |collide_x - e.x| <= MIN_SEP and |collide_y - e.y| <= MIN_SEP.
  - Differences use unsigned subtraction of max minus min; no wrap.
  - A write in cycle N affects collision from cycle N+1; no same-cycle bypass.
- nests_placed and patches_placed are AND-reductions of the valid bits, registered state only.
- Query: registered, latency 1. Sample query_x/query_y at edge N; results valid after edge N.
  - q_nest_hit requires an exact coordinate match.
  - q_patch_hit uses the MIN_SEP square and only patches with sugar > 0.
  - On multiple matches, the lowest index wins.
  - On a miss, the id outputs are 0.
- Take: take_ack is a 1-cycle registered pulse at edge N+1 if the patch is valid and its sugar > 0 at edge N; sugar decrements the same edge.
  - Sugar = 0 or invalid patch: no ack, no change (saturating).
  - take_req held high: one decrement per cycle.
- Simultaneous patch_we and take on the same id: the write wins (sugar = SUGAR_INIT, no ack).
- RESET_SIM mid-operation: immediate clear of all state; no partial write completes.

Decomposition:
- Shared params package holds NEST_num, SUGARPATCH_num, their _bits widths, X_bits, Y_bits, PIXELS_X, PIXELS_Y, MIN_SEP, SUGAR_bits, SUGAR_INIT, plus a packed typedef loc_t {x, y}.
- One sub-module, sep_check: combinational candidate-vs-entry square test (valid, e_loc, c_loc, radius -> hit). It is instantiated per entry for both collision and patch query.

Test Plan:
- Reset, then collide (10,10) -> collision=0; nests_placed=0; every nests_X entry = 0.
- nest_we id0 (50,40), then collide (54,36) -> 1; (55,40) -> 0. Same-cycle query during the write -> 0.
- Write nest 0 and nest 1, then patches 0-3 -> nests_placed=1 one cycle after the last nest write; patches_placed=1 after the last patch write; patch_sugar all 255.
- Query (50,40) -> next cycle q_nest_hit=1, q_nest_id=0. Query at a patch 0 location offset (+3,-3) -> q_patch_hit=1, q_patch_id=0. Two overlapping patches -> lower id reported.
- Hold take_req on patch 2 with SUGAR_INIT=3 -> acks on 3 consecutive cycles, sugar reaches 0, no further acks; subsequent query over patch 2 -> q_patch_hit=0.
- Assert RESET_SIM asynchronously mid-take -> take_ack=0 and all valid bits 0 immediately; collision=0 at any candidate.

Source files
------------

// File: rtl/placement_registry_pkg.sv
// Shared placement parameters and the packed location type used by the
// setup registry and its collision/lookup comparators.
package placement_registry_pkg;

  localparam int NEST_num            = 2;
  localparam int SUGARPATCH_num      = 4;
  localparam int NEST_num_bits       = 1;
  localparam int SUGARPATCH_num_bits = 2;
  localparam int X_bits              = 8;
  localparam int Y_bits              = 7;
  localparam int PIXELS_X            = 1 << X_bits;
  localparam int PIXELS_Y            = 1 << Y_bits;
  localparam int MIN_SEP             = 4;
  localparam int SUGAR_bits          = 8;
  localparam int SUGAR_INIT          = 255;

  typedef struct packed {
    logic [X_bits-1:0] x;
    logic [Y_bits-1:0] y;
  } loc_t;

endpackage

// File: rtl/placement_registry_sep.sv
// Combinational Chebyshev square test: hit when a valid entry lies within
// radius of the candidate on both axes (max-minus-min, no wrap).
module sep_check
  import placement_registry_pkg::*;
(
  input  logic              valid_i,
  input  loc_t              e_loc_i,
  input  loc_t              c_loc_i,
  input  logic [X_bits-1:0] radius_i,
  output logic              hit_o
);

  logic [X_bits-1:0] dx;
  logic [Y_bits-1:0] dy;

  always_comb begin
    dx = (c_loc_i.x >= e_loc_i.x) ? (c_loc_i.x - e_loc_i.x) : (e_loc_i.x - c_loc_i.x);
    dy = (c_loc_i.y >= e_loc_i.y) ? (c_loc_i.y - e_loc_i.y) : (e_loc_i.y - c_loc_i.y);
    hit_o = valid_i && (dx <= radius_i) && (X_bits'(dy) <= radius_i);
  end

endmodule

// File: rtl/placement_registry.sv
// Nest/sugar-patch registry: setup writes, combinational collision query,
// registered run-mode lookups and per-patch sugar depletion.
module placement_registry
  import placement_registry_pkg::*;
#(
  parameter int MIN_SEP    = placement_registry_pkg::MIN_SEP,
  parameter int SUGAR_INIT = placement_registry_pkg::SUGAR_INIT
) (
  input  logic                                          setup_clk,
  input  logic                                          RESET_SIM,
  input  logic                                          nest_we,
  input  logic [NEST_num_bits-1:0]                      nest_id,
  input  logic [X_bits-1:0]                             nest_setup_x,
  input  logic [Y_bits-1:0]                             nest_setup_y,
  input  logic                                          patch_we,
  input  logic [SUGARPATCH_num_bits-1:0]                patch_id,
  input  logic [X_bits-1:0]                             patch_setup_x,
  input  logic [Y_bits-1:0]                             patch_setup_y,
  input  logic [X_bits-1:0]                             collide_x,
  input  logic [Y_bits-1:0]                             collide_y,
  output logic                                          collision,
  output logic [NEST_num-1:0][X_bits-1:0]               nests_X,
  output logic [NEST_num-1:0][Y_bits-1:0]               nests_Y,
  output logic                                          nests_placed,
  output logic                                          patches_placed,
  input  logic [X_bits-1:0]                             query_x,
  input  logic [Y_bits-1:0]                             query_y,
  output logic                                          q_nest_hit,
  output logic [NEST_num_bits-1:0]                      q_nest_id,
  output logic                                          q_patch_hit,
  output logic [SUGARPATCH_num_bits-1:0]                q_patch_id,
  input  logic                                          take_req,
  input  logic [SUGARPATCH_num_bits-1:0]                take_id,
  output logic                                          take_ack,
  output logic [SUGARPATCH_num-1:0][SUGAR_bits-1:0]     patch_sugar
);

  localparam logic [X_bits-1:0]     RADIUS     = X_bits'(MIN_SEP);
  localparam logic [SUGAR_bits-1:0] SUGAR_LOAD = SUGAR_bits'(SUGAR_INIT);

  loc_t [NEST_num-1:0]                       nest_loc_q, nest_loc_d;
  logic [NEST_num-1:0]                       nest_vld_q, nest_vld_d;
  loc_t [SUGARPATCH_num-1:0]                 patch_loc_q, patch_loc_d;
  logic [SUGARPATCH_num-1:0]                 patch_vld_q, patch_vld_d;
  logic [SUGARPATCH_num-1:0][SUGAR_bits-1:0] sugar_q, sugar_d;
  logic                                      q_nest_hit_q, q_nest_hit_d;
  logic [NEST_num_bits-1:0]                  q_nest_id_q, q_nest_id_d;
  logic                                      q_patch_hit_q, q_patch_hit_d;
  logic [SUGARPATCH_num_bits-1:0]            q_patch_id_q, q_patch_id_d;
  logic                                      take_ack_q, take_ack_d;
  logic                                      take_grant;

  loc_t                      cand_loc, query_loc;
  logic [NEST_num-1:0]       nest_coll;
  logic [SUGARPATCH_num-1:0] patch_coll, patch_live, patch_qhit;

  assign cand_loc  = {collide_x, collide_y};
  assign query_loc = {query_x, query_y};

  for (genvar g = 0; g < NEST_num; g++) begin : g_nest
    sep_check u_coll (
      .valid_i (nest_vld_q[g]),
      .e_loc_i (nest_loc_q[g]),
      .c_loc_i (cand_loc),
      .radius_i(RADIUS),
      .hit_o   (nest_coll[g])
    );
  end

  // Collision counts every placed patch; lookups only see patches with sugar left.
  for (genvar g = 0; g < SUGARPATCH_num; g++) begin : g_patch
    assign patch_live[g] = patch_vld_q[g] && (sugar_q[g] != '0);
    sep_check u_coll (
      .valid_i (patch_vld_q[g]),
      .e_loc_i (patch_loc_q[g]),
      .c_loc_i (cand_loc),
      .radius_i(RADIUS),
      .hit_o   (patch_coll[g])
    );
    sep_check u_query (
      .valid_i (patch_live[g]),
      .e_loc_i (patch_loc_q[g]),
      .c_loc_i (query_loc),
      .radius_i(RADIUS),
      .hit_o   (patch_qhit[g])
    );
  end

  assign collision = (|nest_coll) || (|patch_coll);

  always_comb begin
    nest_loc_d  = nest_loc_q;
    nest_vld_d  = nest_vld_q;
    patch_loc_d = patch_loc_q;
    patch_vld_d = patch_vld_q;
    sugar_d     = sugar_q;
    take_grant  = 1'b0;
    for (int i = 0; i < NEST_num; i++) begin
      if (nest_we && (nest_id == NEST_num_bits'(i))) begin
        nest_loc_d[i] = {nest_setup_x, nest_setup_y};
        nest_vld_d[i] = 1'b1;
      end
    end
    for (int i = 0; i < SUGARPATCH_num; i++) begin
      if (take_req && (take_id == SUGARPATCH_num_bits'(i)) && patch_live[i]) begin
        take_grant = 1'b1;
        sugar_d[i] = sugar_q[i] - SUGAR_bits'(1);
      end
      // A placement on the same patch overrides the take and reloads sugar.
      if (patch_we && (patch_id == SUGARPATCH_num_bits'(i))) begin
        patch_loc_d[i] = {patch_setup_x, patch_setup_y};
        patch_vld_d[i] = 1'b1;
        sugar_d[i]     = SUGAR_LOAD;
      end
    end
    take_ack_d = take_grant && !(patch_we && (patch_id == take_id));
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    q_nest_hit_d  = 1'b0;
    q_nest_id_d   = '0;
    q_patch_hit_d = 1'b0;
    q_patch_id_d  = '0;
    for (int i = NEST_num - 1; i >= 0; i--) begin
      if (nest_vld_q[i] && (nest_loc_q[i] == query_loc)) begin
        q_nest_hit_d = 1'b1;
        q_nest_id_d  = NEST_num_bits'(i);
      end
    end
    for (int i = SUGARPATCH_num - 1; i >= 0; i--) begin
      if (patch_qhit[i]) begin
        q_patch_hit_d = 1'b1;
        q_patch_id_d  = SUGARPATCH_num_bits'(i);
      end
    end
  end

  always_ff @(posedge setup_clk or posedge RESET_SIM) begin
    if (RESET_SIM) begin
      nest_loc_q    <= '0;
      nest_vld_q    <= '0;
      patch_loc_q   <= '0;
      patch_vld_q   <= '0;
      sugar_q       <= '0;
      q_nest_hit_q  <= 1'b0;
      q_nest_id_q   <= '0;
      q_patch_hit_q <= 1'b0;
      q_patch_id_q  <= '0;
      take_ack_q    <= 1'b0;
    end else begin
      nest_loc_q    <= nest_loc_d;
      nest_vld_q    <= nest_vld_d;
      patch_loc_q   <= patch_loc_d;
      patch_vld_q   <= patch_vld_d;
      sugar_q       <= sugar_d;
      q_nest_hit_q  <= q_nest_hit_d;
      q_nest_id_q   <= q_nest_id_d;
      q_patch_hit_q <= q_patch_hit_d;
      q_patch_id_q  <= q_patch_id_d;
      take_ack_q    <= take_ack_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NEST_num; i++) begin
      nests_X[i] = nest_loc_q[i].x;
      nests_Y[i] = nest_loc_q[i].y;
    end
  end

  assign nests_placed   = &nest_vld_q;
  assign patches_placed = &patch_vld_q;
  assign q_nest_hit     = q_nest_hit_q;
  assign q_nest_id      = q_nest_id_q;
  assign q_patch_hit    = q_patch_hit_q;
  assign q_patch_id     = q_patch_id_q;
  assign take_ack       = take_ack_q;
  assign patch_sugar    = sugar_q;

endmodule

// File: tb/tb_placement_registry.sv
// Directed bench for placement_registry: drivers queue expected values with a
// due cycle; a negedge monitor pops and compares them, plus every take_ack.
module tb_placement_registry;
  import placement_registry_pkg::*;

  localparam int TB_SUGAR = 3;

  logic setup_clk = 1'b0;
  logic RESET_SIM = 1'b1;
  logic nest_we = 1'b0, patch_we = 1'b0, take_req = 1'b0;
  logic [NEST_num_bits-1:0] nest_id = '0;
  logic [SUGARPATCH_num_bits-1:0] patch_id = '0, take_id = '0;
  logic [X_bits-1:0] nest_setup_x = '0, patch_setup_x = '0, collide_x = '0, query_x = '0;
  logic [Y_bits-1:0] nest_setup_y = '0, patch_setup_y = '0, collide_y = '0, query_y = '0;
  logic collision, nests_placed, patches_placed, q_nest_hit, q_patch_hit, take_ack;
  logic [NEST_num-1:0][X_bits-1:0] nests_X;
  logic [NEST_num-1:0][Y_bits-1:0] nests_Y;
  logic [NEST_num_bits-1:0] q_nest_id;
  logic [SUGARPATCH_num_bits-1:0] q_patch_id;
  logic [SUGARPATCH_num-1:0][SUGAR_bits-1:0] patch_sugar;

  placement_registry #(.MIN_SEP(4), .SUGAR_INIT(TB_SUGAR)) dut (
    .setup_clk(setup_clk), .RESET_SIM(RESET_SIM),
    .nest_we(nest_we), .nest_id(nest_id), .nest_setup_x(nest_setup_x), .nest_setup_y(nest_setup_y),
    .patch_we(patch_we), .patch_id(patch_id), .patch_setup_x(patch_setup_x), .patch_setup_y(patch_setup_y),
    .collide_x(collide_x), .collide_y(collide_y), .collision(collision),
    .nests_X(nests_X), .nests_Y(nests_Y), .nests_placed(nests_placed), .patches_placed(patches_placed),
    .query_x(query_x), .query_y(query_y), .q_nest_hit(q_nest_hit), .q_nest_id(q_nest_id),
    .q_patch_hit(q_patch_hit), .q_patch_id(q_patch_id),
    .take_req(take_req), .take_id(take_id), .take_ack(take_ack), .patch_sugar(patch_sugar)
  );

  // ---- clock / reset ----
  always #5 setup_clk = ~setup_clk;

  int cyc = 0;
  always @(posedge setup_clk) cyc <= cyc + 1;

  // ---- scoreboard state ----
  localparam int S_COLL = 0, S_NPL = 1, S_PPL = 2, S_QNH = 3, S_QNI = 4, S_QPH = 5,
                 S_QPI = 6, S_ACK = 7, S_NX = 8, S_NY = 9, S_SUG = 10;

  typedef struct {int due; int sel; logic [31:0] val;} chk_t;
  typedef struct {int id; logic [SUGAR_bits-1:0] rem;} ack_t;
  chk_t exp_q[$];
  ack_t ack_q[$];
  int n_tests = 0, n_fail = 0;
  bit drain = 1'b0, drained = 1'b0;

  function automatic string sel_name(int s);
    case (s)
      S_COLL: return "collision";
      S_NPL:  return "nests_placed";
      S_PPL:  return "patches_placed";
      S_QNH:  return "q_nest_hit";
      S_QNI:  return "q_nest_id";
      S_QPH:  return "q_patch_hit";
      S_QPI:  return "q_patch_id";
      S_ACK:  return "take_ack";
      S_NX:   return "nests_X";
      S_NY:   return "nests_Y";
      default: return "patch_sugar";
    endcase
  endfunction

  function automatic logic [31:0] get_val(int s);
    case (s)
      S_COLL: return 32'(collision);
      S_NPL:  return 32'(nests_placed);
      S_PPL:  return 32'(patches_placed);
      S_QNH:  return 32'(q_nest_hit);
      S_QNI:  return 32'(q_nest_id);
      S_QPH:  return 32'(q_patch_hit);
      S_QPI:  return 32'(q_patch_id);
      S_ACK:  return 32'(take_ack);
      S_NX:   return 32'(nests_X);
      S_NY:   return 32'(nests_Y);
      default: return 32'(patch_sugar);
    endcase
  endfunction

  // ---- driver tasks ----
  task automatic tick();
    @(posedge setup_clk);
    #1;
  endtask

  task automatic expect_at(input int d, input int s, input logic [31:0] v);
    exp_q.push_back('{cyc + d, s, v});
  endtask

  task automatic expect_ack(input int id, input int rem);
    ack_q.push_back('{id, SUGAR_bits'(rem)});
  endtask

  task automatic write_nest(input int id, input int x, input int y);
    nest_we = 1'b1; nest_id = NEST_num_bits'(id);
    nest_setup_x = X_bits'(x); nest_setup_y = Y_bits'(y);
  endtask

  task automatic write_patch(input int id, input int x, input int y);
    patch_we = 1'b1; patch_id = SUGARPATCH_num_bits'(id);
    patch_setup_x = X_bits'(x); patch_setup_y = Y_bits'(y);
  endtask

  task automatic set_collide(input int x, input int y);
    collide_x = X_bits'(x); collide_y = Y_bits'(y);
  endtask

  task automatic set_query(input int x, input int y);
    query_x = X_bits'(x); query_y = Y_bits'(y);
  endtask

  // ---- monitor ----
  chk_t c;
  ack_t a;
  logic [31:0] act;

  always @(negedge setup_clk) begin
    if (take_ack) begin
      n_tests++;
      if (ack_q.size() == 0) begin
        n_fail++;
        $display("FAIL take_ack_unexpected cyc=%0d: got ack 1, expected 0", cyc);
      end else begin
        a = ack_q.pop_front();
        if (patch_sugar[a.id] !== a.rem) begin
          n_fail++;
          $display("FAIL take_sugar[%0d] cyc=%0d: got %0d, expected %0d", a.id, cyc, patch_sugar[a.id], a.rem);
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= cyc) begin
        c = exp_q[i];
        act = get_val(c.sel);
        n_tests++;
        if ((c.due != cyc) || (act !== c.val)) begin
          n_fail++;
          $display("FAIL %s cyc=%0d due=%0d: got 0x%0h, expected 0x%0h", sel_name(c.sel), cyc, c.due, act, c.val);
        end
        exp_q.delete(i);
      end
    end
    if (drain && !drained) begin
      drained = 1'b1;
      n_tests += 2;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL exp_q_drain: got %0d pending, expected 0", exp_q.size());
      end
      if (ack_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_acks: got %0d outstanding, expected 0", ack_q.size());
      end
    end
  end

  // ---- stimulus ----
  initial begin
    tick(); tick();
    RESET_SIM = 1'b0;

    // reset state
    set_collide(10, 10);
    expect_at(0, S_COLL, 0); expect_at(0, S_NPL, 0); expect_at(0, S_PPL, 0);
    expect_at(0, S_NX, 0);   expect_at(0, S_NY, 0);  expect_at(0, S_SUG, 0);
    expect_at(0, S_QNH, 0);  expect_at(0, S_QPH, 0); expect_at(0, S_ACK, 0);
    tick();

    // nest 0 write: no same-cycle bypass, then square boundaries
    write_nest(0, 50, 40); set_collide(54, 36);
    expect_at(0, S_COLL, 0);
    tick(); nest_we = 1'b0;
    expect_at(0, S_COLL, 1);
    tick(); set_collide(55, 40); expect_at(0, S_COLL, 0);
    tick(); set_collide(46, 44); expect_at(0, S_COLL, 1);
    tick(); set_collide(50, 35); expect_at(0, S_COLL, 0);
    expect_at(0, S_NPL, 0);

    // nest 1
    tick(); write_nest(1, 120, 100);
    expect_at(0, S_NPL, 0); expect_at(1, S_NPL, 1);
    expect_at(1, S_NX, 32'd30770); expect_at(1, S_NY, 32'd12840);
    tick(); nest_we = 1'b0;

    // patches 0..3; patch 1 overlaps patch 0
    write_patch(0, 200, 20); tick();
    write_patch(1, 203, 23); tick();
    write_patch(2, 30, 100); tick();
    write_patch(3, 100, 10);
    expect_at(0, S_PPL, 0); expect_at(1, S_PPL, 1); expect_at(1, S_SUG, 32'h03030303);
    tick(); patch_we = 1'b0;
    set_collide(104, 14); expect_at(0, S_COLL, 1);

    // registered lookups
    set_query(50, 40);
    expect_at(1, S_QNH, 1); expect_at(1, S_QNI, 0); expect_at(1, S_QPH, 0); expect_at(1, S_QPI, 0);
    tick(); set_query(203, 17);
    expect_at(1, S_QNH, 0); expect_at(1, S_QPH, 1); expect_at(1, S_QPI, 0);
    tick(); set_query(203, 23);
    expect_at(1, S_QPH, 1); expect_at(1, S_QPI, 0);
    tick(); set_query(206, 26);
    expect_at(1, S_QPH, 1); expect_at(1, S_QPI, 1);
    tick(); set_query(120, 100);
    expect_at(1, S_QNH, 1); expect_at(1, S_QNI, 1); expect_at(1, S_QPH, 0);
    tick();

    // held take on patch 2: three grants then saturation
    take_req = 1'b1; take_id = 2'd2;
    expect_ack(2, 2); expect_ack(2, 1); expect_ack(2, 0);
    expect_at(4, S_ACK, 0);
    tick(); tick(); tick(); tick();
    take_req = 1'b0;
    expect_at(0, S_SUG, 32'h03000303);
    set_query(30, 100); set_collide(30, 100);
    expect_at(0, S_COLL, 1);
    expect_at(1, S_QPH, 0); expect_at(1, S_QPI, 0);
    tick();

    // write wins over a same-cycle take on the same patch
    take_req = 1'b1; take_id = 2'd0; write_patch(0, 200, 20);
    expect_at(1, S_ACK, 0); expect_at(1, S_SUG, 32'h03000303);
    tick(); take_req = 1'b0; patch_we = 1'b0;
    tick();

    // async reset in the middle of a held take on patch 3
    take_req = 1'b1; take_id = 2'd3; set_collide(104, 14);
    expect_ack(3, 2);
    tick(); tick();
    #2 RESET_SIM = 1'b1;
    expect_at(0, S_ACK, 0); expect_at(0, S_NPL, 0); expect_at(0, S_PPL, 0);
    expect_at(0, S_COLL, 0); expect_at(0, S_SUG, 0); expect_at(0, S_NX, 0);
    tick(); take_req = 1'b0;
    tick(); RESET_SIM = 1'b0;
    set_collide(50, 40); expect_at(0, S_COLL, 0);
    tick(); tick();

    drain = 1'b1;
    @(negedge setup_clk); @(negedge setup_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
